// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and PSR bit positions for the ALU execute stage
package alu_pkg;

  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_ADDC = 8'h07;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_SUBC = 8'h0A;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_MUL  = 8'h0E;
  localparam logic [7:0] OP_PASS = 8'h4F;
  localparam logic [7:0] OP_LSH  = 8'h84;
  localparam logic [7:0] OP_ASHU = 8'h86;

  typedef enum logic [1:0] {IDLE, SHIFT, MUL, DONE} state_e;

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

endpackage

// File: rtl/alu_iter_shifter.sv
// rtl/alu_iter_shifter.sv - one-bit-per-cycle shifter; amount is signed, negative shifts right
module alu_iter_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       amount,
  input  logic             arith,
  input  logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_next
);

  logic [4:0]       count_q;
  logic [WIDTH-1:0] data_q;
  logic             left_q;
  logic             arith_q;
  logic             busy_q;
  logic [4:0]       mag;

  // -16 maps to magnitude 16, which still fits in five bits
  assign mag       = amount[4] ? (~amount + 5'd1) : amount;
  assign data_next = left_q ? {data_q[WIDTH-2:0], 1'b0}
                            : {arith_q & data_q[WIDTH-1], data_q[WIDTH-1:1]};
  // done flags the cycle whose edge performs the final shift step
  assign done      = busy_q && (count_q == 5'd1);
  assign busy      = busy_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      data_q  <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
      busy_q  <= 1'b0;
    end else if (start) begin
      count_q <= mag;
      data_q  <= data_in;
      left_q  <= !amount[4];
      arith_q <= arith;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      data_q  <= data_next;
      count_q <= count_q - 5'd1;
      if (count_q == 5'd1) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// rtl/alu_exec_stage.sv - ALU execute stage with flags and iterative shift; ALU_MUL_EN adds shift-add MUL
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       alu_op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wb_en,
  output logic             illegal,
  output logic [4:0]       psr,
  input  logic             psr_load,
  input  logic [4:0]       psr_in
);

  localparam int MSB = WIDTH - 1;

  state_e           state_q;
  logic [WIDTH-1:0] result_q;
  logic             out_valid_q, wb_en_q, illegal_q;
  logic [4:0]       psr_q;

  logic [WIDTH-1:0] res_d;
  logic [4:0]       flags_d;
  logic             wb_d, ill_d, is_shift, cin;
  logic [WIDTH:0]   sum_d, diff_d;
  logic             accept, shift_start;
  logic             sh_busy, sh_done;
  logic [WIDTH-1:0] sh_next;

  assign in_ready    = ((state_q == IDLE) || (state_q == DONE && out_ready)) && !sh_busy;
  assign accept      = in_valid && in_ready;
  assign shift_start = accept && is_shift && (op_b[4:0] != 5'd0);

  assign cin    = ((alu_op == OP_ADDC) || (alu_op == OP_SUBC)) && psr_q[PSR_C];
  assign sum_d  = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
  assign diff_d = {1'b0, op_a} - {1'b0, op_b} - {{WIDTH{1'b0}}, cin};

`ifdef ALU_MUL_EN
  localparam int MCW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q, acc_nx;
  logic [MCW-1:0]   mcnt_q;
  logic             is_mul;

  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      mcnt_q   <= '0;
    end else if (accept && is_mul) begin
      mcand_q  <= op_a;
      mplier_q <= op_b;
      acc_q    <= '0;
      mcnt_q   <= MCW'(WIDTH);
    end else if (state_q == MUL && mcnt_q != '0) begin
      acc_q    <= acc_nx;
      mcand_q  <= {mcand_q[WIDTH-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[WIDTH-1:1]};
      mcnt_q   <= mcnt_q - MCW'(1);
    end
  end
`endif

  always_comb begin
    res_d    = '0;
    wb_d     = 1'b1;
    ill_d    = 1'b0;
    is_shift = 1'b0;
    flags_d  = psr_q;
`ifdef ALU_MUL_EN
    is_mul   = 1'b0;
`endif
    case (alu_op)
      OP_AND:  res_d = op_a & op_b;
      OP_OR:   res_d = op_a | op_b;
      OP_XOR:  res_d = op_a ^ op_b;
      OP_ADDU: res_d = sum_d[MSB:0];
      OP_ADD, OP_ADDC: begin
        res_d          = sum_d[MSB:0];
        flags_d[PSR_C] = sum_d[WIDTH];
        flags_d[PSR_F] = (op_a[MSB] == op_b[MSB]) && (sum_d[MSB] != op_a[MSB]);
      end
      OP_SUB, OP_SUBC: begin
        res_d          = diff_d[MSB:0];
        flags_d[PSR_C] = diff_d[WIDTH];
        flags_d[PSR_F] = (op_a[MSB] != op_b[MSB]) && (diff_d[MSB] != op_a[MSB]);
      end
      OP_CMP: begin
        wb_d           = 1'b0;
        flags_d[PSR_Z] = (op_a == op_b);
        flags_d[PSR_N] = ($signed(op_a) < $signed(op_b));
        flags_d[PSR_L] = (op_a < op_b);
      end
      OP_MOV:  res_d = op_b;
      OP_PASS: res_d = op_a;
      OP_LSH, OP_ASHU: begin
        is_shift = 1'b1;
        res_d    = op_a;
      end
`ifdef ALU_MUL_EN
      OP_MUL:  is_mul = 1'b1;
`endif
      default: begin
        if (alu_op[7:4] == 4'hF) begin
          res_d = {op_b[7:0], {(WIDTH-8){1'b0}}};
        end else begin
          wb_d  = 1'b0;
          ill_d = 1'b1;
        end
      end
    endcase
  end

  alu_iter_shifter #(.WIDTH(WIDTH)) u_shifter (
    .clock     (clock),
    .reset     (reset),
    .start     (shift_start),
    .amount    (op_b[4:0]),
    .arith     (alu_op == OP_ASHU),
    .data_in   (op_a),
    .busy      (sh_busy),
    .done      (sh_done),
    .data_next (sh_next)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      wb_en_q     <= 1'b0;
      illegal_q   <= 1'b0;
      psr_q       <= '0;
    end else begin
      // an explicit psr load overrides any flag update on the same edge
      if (psr_load)    psr_q <= psr_in;
      else if (accept) psr_q <= flags_d;

      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            illegal_q <= 1'b0;
            if (shift_start) begin
              state_q     <= SHIFT;
              out_valid_q <= 1'b0;
`ifdef ALU_MUL_EN
            end else if (is_mul) begin
              state_q     <= MUL;
              out_valid_q <= 1'b0;
`endif
            end else begin
              state_q     <= DONE;
              out_valid_q <= 1'b1;
              result_q    <= res_d;
              wb_en_q     <= wb_d;
              illegal_q   <= ill_d;
            end
          end else if (state_q == DONE && out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
          end
        end
        SHIFT: begin
          if (sh_done) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= sh_next;
            wb_en_q     <= 1'b1;
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          if (mcnt_q == MCW'(1)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
            result_q    <= acc_nx;
            wb_en_q     <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign wb_en     = wb_en_q;
  assign illegal   = illegal_q;
  assign psr       = psr_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// tb/tb_alu_exec_stage.sv - directed self-checking bench for alu_exec_stage (ALU_MUL_EN aware)
module tb_alu_exec_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  alu_op = 8'h00;
  logic [15:0] op_a = 16'h0;
  logic [15:0] op_b = 16'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        wb_en;
  logic        illegal;
  logic [4:0]  psr;
  logic        psr_load = 1'b0;
  logic [4:0]  psr_in = 5'h0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  alu_exec_stage #(.WIDTH(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .wb_en     (wb_en),
    .illegal   (illegal),
    .psr       (psr),
    .psr_load  (psr_load),
    .psr_in    (psr_in)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one op and count edges after the accept edge until out_valid (0 = N+1 latency)
  task automatic do_op(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       output int t);
    alu_op   = op;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    t = 0;
    while (!out_valid && t < 40) begin
      tick();
      t++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (result !== 16'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0000", result); end
    n_checks++; if (wb_en !== 1'b0 || illegal !== 1'b0) begin n_fail++; $display("FAIL reset_wb_illegal: got %b%b want 00", wb_en, illegal); end
    n_checks++; if (psr !== 5'h0) begin n_fail++; $display("FAIL reset_psr: got %b want 00000", psr); end
    reset = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_add_overflow();
    int t;
    out_ready = 1'b1;
    do_op(8'h05, 16'h7FFF, 16'h0001, t);
    n_checks++; if (t !== 0) begin n_fail++; $display("FAIL add_latency: got %0d want 0", t); end
    n_checks++; if (result !== 16'h8000) begin n_fail++; $display("FAIL add_result: got %h want 8000", result); end
    n_checks++; if (psr !== 5'b00100) begin n_fail++; $display("FAIL add_psr: got %b want 00100", psr); end
    n_checks++; if (wb_en !== 1'b1) begin n_fail++; $display("FAIL add_wb_en: got %b want 1", wb_en); end
  endtask

  task automatic test_back_to_back();
    int t;
    out_ready = 1'b1;
    do_op(8'h05, 16'hFFFF, 16'h0001, t);
    n_checks++; if (result !== 16'h0000 || psr !== 5'b00001) begin n_fail++; $display("FAIL b2b_add: got %h/%b want 0000/00001", result, psr); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    do_op(8'h07, 16'h0001, 16'h0001, t);
    n_checks++; if (t !== 0) begin n_fail++; $display("FAIL b2b_latency: got %0d want 0", t); end
    n_checks++; if (result !== 16'h0003 || psr !== 5'b00000) begin n_fail++; $display("FAIL b2b_addc: got %h/%b want 0003/00000", result, psr); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_cmp();
    int t;
    psr_load = 1'b1;
    psr_in   = 5'b00101;
    tick();
    psr_load = 1'b0;
    n_checks++; if (psr !== 5'b00101) begin n_fail++; $display("FAIL psr_load: got %b want 00101", psr); end
    do_op(8'h0B, 16'h0005, 16'hFFFF, t);
    n_checks++; if (wb_en !== 1'b0 || out_valid !== 1'b1) begin n_fail++; $display("FAIL cmp_wb: got wb=%b ov=%b want 0/1", wb_en, out_valid); end
    n_checks++; if (psr !== 5'b00111) begin n_fail++; $display("FAIL cmp_psr: got %b want 00111", psr); end
  endtask

  task automatic test_logic();
    int t;
    do_op(8'h02, 16'h00F0, 16'h0F00, t);
    n_checks++; if (result !== 16'h0FF0) begin n_fail++; $display("FAIL or: got %h want 0FF0", result); end
    do_op(8'h03, 16'hFFFF, 16'h1234, t);
    n_checks++; if (result !== 16'hEDCB) begin n_fail++; $display("FAIL xor: got %h want EDCB", result); end
    do_op(8'h0D, 16'h1111, 16'hBEEF, t);
    n_checks++; if (result !== 16'hBEEF) begin n_fail++; $display("FAIL mov: got %h want BEEF", result); end
    do_op(8'h4F, 16'hCAFE, 16'h2222, t);
    n_checks++; if (result !== 16'hCAFE) begin n_fail++; $display("FAIL pass: got %h want CAFE", result); end
    do_op(8'hF3, 16'h0000, 16'h12AB, t);
    n_checks++; if (result !== 16'hAB00 || wb_en !== 1'b1) begin n_fail++; $display("FAIL lui: got %h wb=%b want AB00 wb=1", result, wb_en); end
    do_op(8'h06, 16'hFFFF, 16'h0002, t);
    n_checks++; if (result !== 16'h0001 || psr !== 5'b00111) begin n_fail++; $display("FAIL addu: got %h/%b want 0001/00111", result, psr); end
    do_op(8'h09, 16'h8000, 16'h0001, t);
    n_checks++; if (result !== 16'h7FFF || psr !== 5'b00110) begin n_fail++; $display("FAIL sub: got %h/%b want 7FFF/00110", result, psr); end
    do_op(8'h0A, 16'h0000, 16'h0001, t);
    n_checks++; if (result !== 16'hFFFF || psr !== 5'b00011) begin n_fail++; $display("FAIL subc0: got %h/%b want FFFF/00011", result, psr); end
    do_op(8'h0A, 16'h0005, 16'h0002, t);
    n_checks++; if (result !== 16'h0002 || psr !== 5'b00010) begin n_fail++; $display("FAIL subc1: got %h/%b want 0002/00010", result, psr); end
  endtask

  task automatic test_shift();
    int t;
    do_op(8'h86, 16'h8000, 16'h001C, t);
    n_checks++; if (t !== 4) begin n_fail++; $display("FAIL ashu_latency: got %0d want 4", t); end
    n_checks++; if (result !== 16'hF800 || wb_en !== 1'b1) begin n_fail++; $display("FAIL ashu_result: got %h wb=%b want F800 wb=1", result, wb_en); end
    n_checks++; if (psr !== 5'b00010) begin n_fail++; $display("FAIL shift_psr: got %b want 00010", psr); end
    do_op(8'h84, 16'h1234, 16'h0020, t);
    n_checks++; if (t !== 0 || result !== 16'h1234) begin n_fail++; $display("FAIL lsh_zero: got t=%0d %h want t=0 1234", t, result); end
    do_op(8'h84, 16'h0001, 16'h000F, t);
    n_checks++; if (t !== 15 || result !== 16'h8000) begin n_fail++; $display("FAIL lsh_15: got t=%0d %h want t=15 8000", t, result); end
    do_op(8'h84, 16'hFFFF, 16'h0010, t);
    n_checks++; if (t !== 16 || result !== 16'h0000) begin n_fail++; $display("FAIL lsh_m16: got t=%0d %h want t=16 0000", t, result); end
    do_op(8'h86, 16'h8000, 16'h0010, t);
    n_checks++; if (t !== 16 || result !== 16'hFFFF) begin n_fail++; $display("FAIL ashu_m16: got t=%0d %h want t=16 FFFF", t, result); end
  endtask

  task automatic test_op_0e();
    int t;
`ifdef ALU_MUL_EN
    do_op(8'h0E, 16'h0003, 16'h0005, t);
    n_checks++; if (t !== 16) begin n_fail++; $display("FAIL mul_latency: got %0d want 16", t); end
    n_checks++; if (result !== 16'h000F || wb_en !== 1'b1 || illegal !== 1'b0) begin n_fail++; $display("FAIL mul_result: got %h wb=%b ill=%b want 000F 1 0", result, wb_en, illegal); end
`else
    do_op(8'h0E, 16'h0003, 16'h0005, t);
    n_checks++; if (t !== 0) begin n_fail++; $display("FAIL op0e_latency: got %0d want 0", t); end
    n_checks++; if (result !== 16'h0000 || wb_en !== 1'b0 || illegal !== 1'b1) begin n_fail++; $display("FAIL op0e_illegal: got %h wb=%b ill=%b want 0000 0 1", result, wb_en, illegal); end
`endif
    n_checks++; if (psr !== 5'b00010) begin n_fail++; $display("FAIL op0e_psr: got %b want 00010", psr); end
    do_op(8'h00, 16'h1234, 16'h5678, t);
    n_checks++; if (illegal !== 1'b1 || wb_en !== 1'b0 || result !== 16'h0000) begin n_fail++; $display("FAIL illegal_00: got ill=%b wb=%b %h want 1 0 0000", illegal, wb_en, result); end
    tick();
    n_checks++; if (illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_pulse: got %b want 0", illegal); end
  endtask

  task automatic test_hold();
    int t;
    out_ready = 1'b0;
    do_op(8'h01, 16'hF0F0, 16'hFF00, t);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1 || result !== 16'hF000 || in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_%0d: got ov=%b %h rdy=%b want 1 F000 0", i, out_valid, result, in_ready); end
    end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL hold_release: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_shift();
    alu_op   = 8'h84;
    op_a     = 16'h0001;
    op_b     = 16'h000A;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_shift_busy: got ov=%b rdy=%b want 0 0", out_valid, in_ready); end
    reset = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || result !== 16'h0 || wb_en !== 1'b0 || illegal !== 1'b0 || psr !== 5'h0) begin n_fail++; $display("FAIL async_reset: got ov=%b %h wb=%b ill=%b psr=%b want all zero", out_valid, result, wb_en, illegal, psr); end
    tick();
    reset = 1'b1;
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready: got %b want 1", in_ready); end
    for (int i = 0; i < 12; i++) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL discarded_op: got %b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_cmp();
    test_logic();
    test_shift();
    test_op_0e();
    test_hold();
    test_reset_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
